// File: rtl/regfile_wb_scoreboard.sv
// regfile_wb_scoreboard: decode-stage register file with write-back mux, write-to-read bypass,
// hardwired zero register and a per-register busy scoreboard that raises stall on pending operands.
module regfile_wb_scoreboard #(
  parameter int DATA_W   = 64,
  parameter int NUM_REGS = 32,
  parameter int ZERO_REG = 31,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [31:0]         instruction,
  input  logic                Reg2Loc,
  input  logic                RegWrite,
  input  logic [4:0]          WriteReg,
  input  logic                MemToReg,
  input  logic [DATA_W-1:0]   dataMemOutput,
  input  logic [DATA_W-1:0]   mult_alu_shift_data,
  input  logic                issue_busy,
  input  logic [4:0]          issue_reg,
  output logic [DATA_W-1:0]   ReadData1,
  output logic [DATA_W-1:0]   ReadData2,
  output logic                stall,
  output logic [NUM_REGS-1:0] busy_vec
);
  localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;
  localparam logic [5:0] NR = 6'(NUM_REGS);
  localparam logic [4:0] ZR = 5'(ZERO_REG);
  logic [DATA_W-1:0] r_regs [NUM_REGS];
  logic [NUM_REGS-1:0] r_busy, w_set, w_clr;
  logic [4:0] w_rr1, w_rr2;
  logic [DATA_W-1:0] w_wd;
  logic w_v1, w_v2, w_wr_ok, w_byp1, w_byp2;
  assign w_rr1 = instruction[9:5];
  assign w_rr2 = Reg2Loc ? instruction[4:0] : instruction[20:16];
  assign w_wd = MemToReg ? dataMemOutput : mult_alu_shift_data;
  // Valid read index: inside the array and not the zero register
  assign w_v1 = ({1'b0, w_rr1} < NR) && (w_rr1 != ZR);
  assign w_v2 = ({1'b0, w_rr2} < NR) && (w_rr2 != ZR);
  assign w_wr_ok = RegWrite && ({1'b0, WriteReg} < NR) && (WriteReg != ZR);
  assign w_byp1 = (BYPASS != 0) && RegWrite && (WriteReg == w_rr1);
  assign w_byp2 = (BYPASS != 0) && RegWrite && (WriteReg == w_rr2);
  assign ReadData1 = !w_v1 ? '0 : w_byp1 ? w_wd : r_regs[w_rr1[AW-1:0]];
  assign ReadData2 = !w_v2 ? '0 : w_byp2 ? w_wd : r_regs[w_rr2[AW-1:0]];
  assign stall = (w_v1 && r_busy[w_rr1[AW-1:0]] && !w_byp1) ||
                 (w_v2 && r_busy[w_rr2[AW-1:0]] && !w_byp2);
  assign busy_vec = r_busy;
  always_comb begin
    w_set = '0;
    w_clr = '0;
    for (int k = 0; k < NUM_REGS; k++) begin
      w_set[k] = issue_busy && (issue_reg == 5'(k)) && (5'(k) != ZR);
      w_clr[k] = RegWrite && (WriteReg == 5'(k));
    end
  end
  // Set is applied after clear so a new producer issued alongside a commit stays outstanding
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < NUM_REGS; k++) r_regs[k] <= '0;
      r_busy <= '0;
    end else begin
      if (w_wr_ok) r_regs[WriteReg[AW-1:0]] <= w_wd;
      r_busy <= (r_busy & ~w_clr) | w_set;
    end
  end
endmodule

// File: tb/tb_regfile_wb_scoreboard.sv
// tb_regfile_wb_scoreboard: directed bench driving a bypassing and a non-bypassing instance in parallel.
module tb_regfile_wb_scoreboard;
  logic clk = 0, reset = 0, Reg2Loc = 0, RegWrite = 0, MemToReg = 0, issue_busy = 0;
  logic [31:0] instruction = 0;
  logic [4:0] WriteReg = 0, issue_reg = 0;
  logic [63:0] dataMemOutput = 0, mult_alu_shift_data = 0;
  logic [63:0] rd1, rd2, nb_rd1, nb_rd2;
  logic stall, nb_stall;
  logic [31:0] busy_vec, nb_busy_vec;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  regfile_wb_scoreboard #(.DATA_W(64), .NUM_REGS(32), .ZERO_REG(31), .BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .instruction(instruction), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite),
    .WriteReg(WriteReg), .MemToReg(MemToReg), .dataMemOutput(dataMemOutput),
    .mult_alu_shift_data(mult_alu_shift_data), .issue_busy(issue_busy), .issue_reg(issue_reg),
    .ReadData1(rd1), .ReadData2(rd2), .stall(stall), .busy_vec(busy_vec));

  regfile_wb_scoreboard #(.DATA_W(64), .NUM_REGS(32), .ZERO_REG(31), .BYPASS(0)) u_nb (
    .clk(clk), .reset(reset), .instruction(instruction), .Reg2Loc(Reg2Loc), .RegWrite(RegWrite),
    .WriteReg(WriteReg), .MemToReg(MemToReg), .dataMemOutput(dataMemOutput),
    .mult_alu_shift_data(mult_alu_shift_data), .issue_busy(issue_busy), .issue_reg(issue_reg),
    .ReadData1(nb_rd1), .ReadData2(nb_rd2), .stall(nb_stall), .busy_vec(nb_busy_vec));

  function automatic logic [31:0] ins(input logic [4:0] rn, input logic [4:0] rm, input logic [4:0] rt);
    return {11'b0, rm, 6'b0, rn, rt};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    RegWrite = 0; issue_busy = 0; reset = 0;
  endtask

  task automatic test_reset();
    reset = 1; RegWrite = 1; WriteReg = 1; mult_alu_shift_data = 64'h1; issue_busy = 1; issue_reg = 1;
    tick();
    reset = 1; RegWrite = 0; issue_busy = 0;
    tick();
    idle(); instruction = ins(1, 2, 0); Reg2Loc = 0;
    #1;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL reset_busy got %h exp 0", busy_vec); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %b exp 0", stall); end
    checks++; if (rd1 !== 64'h0) begin errors++; $display("FAIL reset_rd1 got %h exp 0", rd1); end
    checks++; if (rd2 !== 64'h0) begin errors++; $display("FAIL reset_rd2 got %h exp 0", rd2); end
    checks++; if (nb_rd1 !== 64'h0) begin errors++; $display("FAIL reset_nb_rd1 got %h exp 0", nb_rd1); end
  endtask

  task automatic test_write_read();
    RegWrite = 1; WriteReg = 3; MemToReg = 0; mult_alu_shift_data = 64'h1234; dataMemOutput = 64'h9999;
    tick();
    WriteReg = 4; MemToReg = 1; dataMemOutput = 64'hDEAD_BEEF; mult_alu_shift_data = 64'h1111;
    tick();
    idle(); instruction = ins(3, 4, 3); Reg2Loc = 0;
    #1;
    checks++; if (rd1 !== 64'h1234) begin errors++; $display("FAIL wr_rd1 got %h exp 1234", rd1); end
    checks++; if (rd2 !== 64'hDEAD_BEEF) begin errors++; $display("FAIL wr_rd2_rm got %h exp deadbeef", rd2); end
    checks++; if (nb_rd2 !== 64'hDEAD_BEEF) begin errors++; $display("FAIL wr_nb_rd2 got %h exp deadbeef", nb_rd2); end
    Reg2Loc = 1;
    #1;
    checks++; if (rd2 !== 64'h1234) begin errors++; $display("FAIL wr_rd2_rt got %h exp 1234", rd2); end
  endtask

  task automatic test_zero();
    RegWrite = 1; WriteReg = 31; MemToReg = 0; mult_alu_shift_data = 64'hFFFF;
    instruction = ins(31, 31, 0); Reg2Loc = 0;
    #1;
    checks++; if (rd1 !== 64'h0) begin errors++; $display("FAIL zero_same_cycle got %h exp 0", rd1); end
    checks++; if (rd2 !== 64'h0) begin errors++; $display("FAIL zero_same_cycle_p2 got %h exp 0", rd2); end
    tick();
    idle();
    #1;
    checks++; if (rd1 !== 64'h0) begin errors++; $display("FAIL zero_after got %h exp 0", rd1); end
    checks++; if (nb_rd1 !== 64'h0) begin errors++; $display("FAIL zero_after_nb got %h exp 0", nb_rd1); end
    issue_busy = 1; issue_reg = 31;
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL zero_busy got %h exp 0", busy_vec); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL zero_stall got %b exp 0", stall); end
  endtask

  task automatic test_bypass();
    RegWrite = 1; WriteReg = 5; MemToReg = 0; mult_alu_shift_data = 64'h55;
    instruction = ins(5, 3, 0); Reg2Loc = 0;
    #1;
    checks++; if (rd1 !== 64'h55) begin errors++; $display("FAIL byp_rd1 got %h exp 55", rd1); end
    checks++; if (rd2 !== 64'h1234) begin errors++; $display("FAIL byp_rd2_unaffected got %h exp 1234", rd2); end
    checks++; if (nb_rd1 !== 64'h0) begin errors++; $display("FAIL nobyp_old got %h exp 0", nb_rd1); end
    instruction = ins(3, 5, 0);
    #1;
    checks++; if (rd2 !== 64'h55) begin errors++; $display("FAIL byp_rd2 got %h exp 55", rd2); end
    checks++; if (rd1 !== 64'h1234) begin errors++; $display("FAIL byp_rd1_unaffected got %h exp 1234", rd1); end
    tick();
    idle(); instruction = ins(5, 5, 0);
    #1;
    checks++; if (nb_rd1 !== 64'h55) begin errors++; $display("FAIL nobyp_next got %h exp 55", nb_rd1); end
    checks++; if (rd1 !== 64'h55) begin errors++; $display("FAIL byp_next got %h exp 55", rd1); end
  endtask

  task automatic test_scoreboard();
    issue_busy = 1; issue_reg = 7; instruction = ins(7, 0, 0); Reg2Loc = 0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_set_cycle got %b exp 0", stall); end
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== 32'h80) begin errors++; $display("FAIL sb_busy got %h exp 80", busy_vec); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_hold%0d got %b exp 1", i, stall); end
      tick();
    end
    RegWrite = 1; WriteReg = 7; MemToReg = 0; mult_alu_shift_data = 64'h77;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL sb_wb_stall got %b exp 0", stall); end
    checks++; if (rd1 !== 64'h77) begin errors++; $display("FAIL sb_wb_rd1 got %h exp 77", rd1); end
    checks++; if (nb_stall !== 1'b1) begin errors++; $display("FAIL sb_wb_nb_stall got %b exp 1", nb_stall); end
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL sb_clear got %h exp 0", busy_vec); end
    checks++; if (nb_stall !== 1'b0) begin errors++; $display("FAIL sb_clear_nb_stall got %b exp 0", nb_stall); end
    instruction = ins(0, 7, 0);
    issue_busy = 1; issue_reg = 7; RegWrite = 1; WriteReg = 7; mult_alu_shift_data = 64'h78;
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== 32'h80) begin errors++; $display("FAIL sb_set_wins got %h exp 80", busy_vec); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL sb_set_wins_stall_rm got %b exp 1", stall); end
    checks++; if (rd2 !== 64'h78) begin errors++; $display("FAIL sb_set_wins_data got %h exp 78", rd2); end
  endtask

  task automatic test_reset_pending();
    issue_busy = 1; issue_reg = 2;
    tick();
    idle();
    #1;
    checks++; if (busy_vec !== 32'h84) begin errors++; $display("FAIL rp_busy got %h exp 84", busy_vec); end
    reset = 1; RegWrite = 1; WriteReg = 2; MemToReg = 0; mult_alu_shift_data = 64'hABC;
    issue_busy = 1; issue_reg = 9;
    tick();
    idle(); instruction = ins(2, 3, 0); Reg2Loc = 0;
    #1;
    checks++; if (busy_vec !== 32'h0) begin errors++; $display("FAIL rp_busy_clr got %h exp 0", busy_vec); end
    checks++; if (rd1 !== 64'h0) begin errors++; $display("FAIL rp_x2 got %h exp 0", rd1); end
    checks++; if (rd2 !== 64'h0) begin errors++; $display("FAIL rp_x3 got %h exp 0", rd2); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL rp_stall got %b exp 0", stall); end
  endtask

  task automatic test_back_to_back();
    logic [63:0] vals [4];
    vals[0] = 64'h0123_4567_89AB_CDEF; vals[1] = 64'hFFFF_FFFF_FFFF_FFFF;
    vals[2] = 64'h8000_0000_0000_0001; vals[3] = 64'h0000_0000_0000_00A5;
    for (int i = 0; i < 4; i++) begin
      RegWrite = 1; WriteReg = 5'(10 + i); MemToReg = i[0];
      dataMemOutput = vals[i]; mult_alu_shift_data = ~vals[i];
      tick();
    end
    idle();
    for (int i = 0; i < 2; i++) begin
      instruction = ins(5'(10 + 2 * i), 5'(11 + 2 * i), 0); Reg2Loc = 0;
      #1;
      checks++; if (rd1 !== ~vals[2 * i]) begin errors++; $display("FAIL b2b_rd1_%0d got %h exp %h", i, rd1, ~vals[2 * i]); end
      checks++; if (nb_rd2 !== vals[2 * i + 1]) begin errors++; $display("FAIL b2b_rd2_%0d got %h exp %h", i, nb_rd2, vals[2 * i + 1]); end
    end
  endtask

  initial begin
    tick();
    test_reset();
    test_write_read();
    test_zero();
    test_bypass();
    test_scoreboard();
    test_reset_pending();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_wb_scoreboard.md
Name: regfile_wb_scoreboard

Overview:
Parametrised successor to the decode-stage register-file block. It merges read-register selection, write-back data selection and the register array with three additions: a write-to-read bypass, a hardwired zero register, and a per-register busy scoreboard for long-latency (multiplier/load) results. It sits between the decode and write-back stages and raises a stall when an operand is still pending.

Parameters:
DATA_W, 64, register and data width in bits.
NUM_REGS, 32, number of architectural registers; legal range 2..32; address fields are always 5 bits.
ZERO_REG, 31, index that always reads 0 and ignores writes (XZR).
BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = reads return array contents only.

Ports:
clk  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
instruction  in  32  decode-stage instruction; Rn = [9:5], Rm = [20:16], Rt = [4:0].
Reg2Loc  in  1  1 = ReadReg2 is instruction[4:0]; 0 = ReadReg2 is instruction[20:16].
RegWrite  in  1  write-back enable.
WriteReg  in  5  write-back destination register.
MemToReg  in  1  1 = write data is dataMemOutput; 0 = write data is mult_alu_shift_data.
dataMemOutput  in  DATA_W  load result.
mult_alu_shift_data  in  DATA_W  ALU/shift/multiply result.
issue_busy  in  1  a long-latency op targeting issue_reg is issuing this cycle.
issue_reg  in  5  destination register of that long-latency op.
ReadData1  out  DATA_W  contents of Rn.
ReadData2  out  DATA_W  contents of ReadReg2.
stall  out  1  at least one read operand is pending.
busy_vec  out  NUM_REGS  scoreboard state, for debug.

Behaviour:
- Read ports:
  - ReadReg1 = instruction[9:5]. ReadReg2 is selected by Reg2Loc as listed under Ports.
  - Register indices >= NUM_REGS read 0, are never busy, and writes to them are dropped.
  - Reads are combinational, with zero latency.
- WriteData = MemToReg ? dataMemOutput : mult_alu_shift_data, full DATA_W, no extension.
- Write: on posedge with RegWrite=1 and WriteReg != ZERO_REG and WriteReg < NUM_REGS, array[WriteReg] <= WriteData.
- ZERO_REG:
  - Always reads 0, including when it is the target of a same-cycle write.
  - Never marked busy.
- Bypass (BYPASS=1): if RegWrite=1 and WriteReg equals a valid, non-zero read index, that port outputs WriteData in the same cycle. Bypass applies to each read port independently.
- Bypass disabled (BYPASS=0): the new value is visible the cycle after the write.
- Scoreboard, per register, updated on posedge:
  - set: issue_busy=1 and issue_reg valid and != ZERO_REG.
  - clear: a committing write to that register (RegWrite=1 and WriteReg equals that index).
  - Set and clear on the same register in the same cycle: set wins; the new producer is outstanding.
  - A write to a non-busy register is allowed and leaves the bit at 0.
- stall is combinational and is 1 when either condition holds:
  - (Rn is busy) AND NOT (BYPASS=1 AND RegWrite=1 AND WriteReg == Rn);
  - the same condition for ReadReg2.
  - A busy bit being set this cycle does not affect stall until the next cycle.
- Reset (synchronous):
  - All array entries go to 0 and busy_vec goes to 0.
  - Consequently stall=0 and ReadData1/ReadData2 = 0 in the cycle after reset is sampled, unless a bypass is active.
  - A write or issue coincident with reset is discarded; reset wins.
  - Reset mid-operation abandons all pending busy bits.
- No X propagation: every output is defined when all inputs are known.

Test Plan:
1. Reset: assert reset for 1 clk -> busy_vec=0, stall=0, ReadData1=ReadData2=0 for any instruction.
2. Write/read with mux select:
   - Write X3=0x1234 via ALU (MemToReg=0), then X4=0xDEAD_BEEF via mem (MemToReg=1).
   - Next cycle, instruction with Rn=3, Rm=4, Reg2Loc=0 -> ReadData1=0x1234, ReadData2=0xDEAD_BEEF.
   - Same instruction with Reg2Loc=1 and Rt=3 -> ReadData2=0x1234.
3. Zero register: write X31=0xFFFF with RegWrite=1 -> ReadData of X31 is 0 both in the write cycle and after it. busy_vec[31] stays 0 after issue_busy with issue_reg=31.
4. Bypass:
   - BYPASS=1: write X5=0x55 and read Rn=5 in the same cycle -> ReadData1=0x55 that cycle.
   - BYPASS=0, same stimulus -> ReadData1 shows the old value that cycle and 0x55 on the next.
5. Scoreboard stall:
   - issue_busy with issue_reg=7; next cycle read Rn=7 -> stall=1.
   - Hold for 3 cycles, then write X7=0x77 -> stall=0 in the write cycle (BYPASS=1) with ReadData1=0x77; busy_vec[7]=0 afterwards.
   - Simultaneous issue_busy and write to X7 -> busy_vec[7]=1 afterwards.
6. Reset during pending: busy_vec[2]=1, assert reset together with a RegWrite to X2 -> after reset busy_vec=0 and X2 reads 0, so the write is discarded.
